// File: rtl/mcpu_mem_arb_csr_pkg.sv
// Shared constants for the memory-arbiter CSR block:
// register offsets, CTRL bit positions and counter widths.
package mcpu_mem_arb_csr_pkg;
  localparam int CNT_W = 32;
  localparam int RUN_W = 16;

  localparam logic [7:0] ADDR_CTRL  = 8'h00;
  localparam logic [7:0] ADDR_LIMIT = 8'h01;
  localparam logic [7:0] ADDR_STAT  = 8'h02;
  localparam logic [7:0] ADDR_MASK  = 8'h03;

  localparam logic [3:0] PAGE_CRED  = 4'h1;
  localparam logic [3:0] PAGE_GRANT = 4'h2;
  localparam logic [3:0] PAGE_STALL = 4'h3;

  localparam int CTRL_EN  = 0;
  localparam int CTRL_CLR = 1;
endpackage

// File: rtl/mcpu_mem_arb_csr_cli.sv
// Per-client monitor: saturating grant/stall counters,
// stall-run tracker and sticky starvation status bit.
module mcpu_mem_arb_csr_cli
  import mcpu_mem_arb_csr_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             valid_i,
  input  logic             stall_i,
  input  logic             count_en_i,
  input  logic             clear_i,
  input  logic [RUN_W-1:0] limit_i,
  input  logic             w1c_i,
  output logic [CNT_W-1:0] grant_cnt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic             stat_o
);

  logic             grant;
  logic             stalled;
  logic             hit;
  logic [CNT_W-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic             stat_q, stat_d;

  assign grant   = valid_i & ~stall_i;
  assign stalled = valid_i & stall_i;
  // Equality only: lowering the limit below the run never fires.
  assign hit = stalled && (limit_i != '0) &&
               (({1'b0, run_q} + 17'd1) == {1'b0, limit_i});

  // Next-state: clear beats counting, set beats W1C.
  always_comb begin
    grant_d = grant_q;
    stall_d = stall_q;
    run_d   = '0;
    if (clear_i) begin
      grant_d = '0;
      stall_d = '0;
    end else begin
      if (count_en_i && grant && grant_q != '1)
        grant_d = grant_q + CNT_W'(1);
      if (count_en_i && stalled && stall_q != '1)
        stall_d = stall_q + CNT_W'(1);
      if (stalled)
        run_d = (run_q == '1) ? run_q : run_q + RUN_W'(1);
    end
    stat_d = hit | (stat_q & ~w1c_i);
  end

  // State registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      grant_q <= '0;
      stall_q <= '0;
      run_q   <= '0;
      stat_q  <= 1'b0;
    end else begin
      grant_q <= grant_d;
      stall_q <= stall_d;
      run_q   <= run_d;
      stat_q  <= stat_d;
    end
  end

  assign grant_cnt_o = grant_q;
  assign stall_cnt_o = stall_q;
  assign stat_o      = stat_q;

endmodule

// File: rtl/mcpu_mem_arb_csr.sv
// CSR block beside the memory arbiter: credit weights,
// per-client grant/stall counters and starvation interrupt.
module mcpu_mem_arb_csr
  import mcpu_mem_arb_csr_pkg::*;
#(
  parameter int CLIENTS         = 2,
  parameter int CREDITS_BITS    = 3,
  parameter int CREDITS_DEFAULT = 1,
  parameter int STARVE_DEFAULT  = 256
) (
  input  logic                            clkrst_mem_clk,
  input  logic                            clkrst_mem_rst,
  input  logic                            csr_valid,
  input  logic                            csr_write,
  input  logic [7:0]                      csr_addr,
  input  logic [31:0]                     csr_wdata,
  output logic [31:0]                     csr_rdata,
  output logic                            csr_rvalid,
  input  logic [CLIENTS-1:0]              cli2arb_valid,
  input  logic [CLIENTS-1:0]              cli2arb_stall,
  output logic [CLIENTS*CREDITS_BITS-1:0] arb_credits,
  output logic                            starve_irq
);

  localparam logic [CREDITS_BITS-1:0] CRED_RST =
    CREDITS_BITS'(CREDITS_DEFAULT);

  logic                                  wr, rd;
  logic [3:0]                            page, idx;
  logic                                  sel_ctrl, sel_lim;
  logic                                  sel_stat, sel_mask;
  logic                                  sel_cred, sel_gnt, sel_stl;
  logic                                  clear;
  logic [CLIENTS-1:0]                    w1c, stat;
  logic                                  en_q;
  logic [RUN_W-1:0]                      limit_q;
  logic [CLIENTS-1:0]                    mask_q;
  logic [CLIENTS-1:0][CREDITS_BITS-1:0]  cred_q;
  logic [CLIENTS-1:0][CNT_W-1:0]         gnt_cnt, stl_cnt;
  logic [31:0]                           rd_mux, rdata_q;
  logic                                  rvalid_q, irq_q;
  logic                                  unused_wdata;

  assign wr       = csr_valid & csr_write;
  assign rd       = csr_valid & ~csr_write;
  assign page     = csr_addr[7:4];
  assign idx      = csr_addr[3:0];
  assign sel_ctrl = (csr_addr == ADDR_CTRL);
  assign sel_lim  = (csr_addr == ADDR_LIMIT);
  assign sel_stat = (csr_addr == ADDR_STAT);
  assign sel_mask = (csr_addr == ADDR_MASK);
  assign sel_cred = (page == PAGE_CRED);
  assign sel_gnt  = (page == PAGE_GRANT);
  assign sel_stl  = (page == PAGE_STALL);
  assign clear    = wr & sel_ctrl & csr_wdata[CTRL_CLR];
  assign w1c      = (wr & sel_stat) ? csr_wdata[CLIENTS-1:0] : '0;
  assign unused_wdata = ^csr_wdata;

  for (genvar c = 0; c < CLIENTS; c++) begin : g_cli
    mcpu_mem_arb_csr_cli u_cli (
      .clk_i       (clkrst_mem_clk),
      .rst_i       (clkrst_mem_rst),
      .valid_i     (cli2arb_valid[c]),
      .stall_i     (cli2arb_stall[c]),
      .count_en_i  (en_q),
      .clear_i     (clear),
      .limit_i     (limit_q),
      .w1c_i       (w1c[c]),
      .grant_cnt_o (gnt_cnt[c]),
      .stall_cnt_o (stl_cnt[c]),
      .stat_o      (stat[c])
    );
  end

  // Writable config registers; writes to holes are dropped.
  always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
    if (clkrst_mem_rst) begin
      en_q    <= 1'b1;
      limit_q <= RUN_W'(STARVE_DEFAULT);
      mask_q  <= '0;
      cred_q  <= {CLIENTS{CRED_RST}};
    end else if (wr) begin
      if (sel_ctrl) en_q <= csr_wdata[CTRL_EN];
      if (sel_lim) limit_q <= csr_wdata[RUN_W-1:0];
      if (sel_mask) mask_q <= csr_wdata[CLIENTS-1:0];
      for (int c = 0; c < CLIENTS; c++)
        if (sel_cred && idx == 4'(c))
          cred_q[c] <= csr_wdata[CREDITS_BITS-1:0];
    end
  end

  // Read mux over current state, so reads see pre-update values.
  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      sel_ctrl: rd_mux[CTRL_EN] = en_q;
      sel_lim:  rd_mux[RUN_W-1:0] = limit_q;
      sel_stat: rd_mux[CLIENTS-1:0] = stat;
      sel_mask: rd_mux[CLIENTS-1:0] = mask_q;
      sel_cred: begin
        for (int c = 0; c < CLIENTS; c++)
          if (idx == 4'(c))
            rd_mux[CREDITS_BITS-1:0] = cred_q[c];
      end
      sel_gnt: begin
        for (int c = 0; c < CLIENTS; c++)
          if (idx == 4'(c)) rd_mux = gnt_cnt[c];
      end
      sel_stl: begin
        for (int c = 0; c < CLIENTS; c++)
          if (idx == 4'(c)) rd_mux = stl_cnt[c];
      end
      default: rd_mux = '0;
    endcase
  end

  // Registered read response and level interrupt.
  always_ff @(posedge clkrst_mem_clk or posedge clkrst_mem_rst) begin
    if (clkrst_mem_rst) begin
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      irq_q    <= 1'b0;
    end else begin
      rvalid_q <= rd;
      if (rd) rdata_q <= rd_mux;
      irq_q <= |(stat & mask_q);
    end
  end

  assign csr_rdata   = rdata_q;
  assign csr_rvalid  = rvalid_q;
  assign starve_irq  = irq_q;
  assign arb_credits = cred_q;

endmodule

// File: tb/tb_mcpu_mem_arb_csr.sv
// Directed bench for mcpu_mem_arb_csr with a per-cycle
// behavioural model and literal spot checks.
module tb_mcpu_mem_arb_csr;

  logic        clk = 0;
  logic        rst = 1;
  logic        csr_valid = 0;
  logic        csr_write = 0;
  logic [7:0]  csr_addr = 0;
  logic [31:0] csr_wdata = 0;
  logic [31:0] csr_rdata;
  logic        csr_rvalid;
  logic [1:0]  valid = 0;
  logic [1:0]  stall = 0;
  logic [5:0]  arb_credits;
  logic        starve_irq;

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  mcpu_mem_arb_csr dut (
    .clkrst_mem_clk (clk),
    .clkrst_mem_rst (rst),
    .csr_valid      (csr_valid),
    .csr_write      (csr_write),
    .csr_addr       (csr_addr),
    .csr_wdata      (csr_wdata),
    .csr_rdata      (csr_rdata),
    .csr_rvalid     (csr_rvalid),
    .cli2arb_valid  (valid),
    .cli2arb_stall  (stall),
    .arb_credits    (arb_credits),
    .starve_irq     (starve_irq)
  );

  // Model state, in plain integers.
  bit          m_en;
  int          m_limit;
  bit [1:0]    m_stat, m_mask;
  int          m_cred[2];
  longint      m_gnt[2], m_stl[2];
  int          m_run[2];
  bit          m_irq, m_rv;
  logic [31:0] m_rd;

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    m_en = 1; m_limit = 256; m_stat = 0; m_mask = 0;
    m_irq = 0; m_rv = 0; m_rd = 0;
    for (int c = 0; c < 2; c++) begin
      m_cred[c] = 1; m_gnt[c] = 0; m_stl[c] = 0; m_run[c] = 0;
    end
  endtask

  function automatic logic [31:0] m_read(input int a);
    logic [31:0] r;
    r = 0;
    if (a == 0) r = 32'(m_en);
    else if (a == 1) r = 32'(m_limit);
    else if (a == 2) r = 32'(m_stat);
    else if (a == 3) r = 32'(m_mask);
    else if (a == 'h10 || a == 'h11) r = 32'(m_cred[a-'h10]);
    else if (a == 'h20 || a == 'h21) r = 32'(m_gnt[a-'h20]);
    else if (a == 'h30 || a == 'h31) r = 32'(m_stl[a-'h30]);
    return r;
  endfunction

  task automatic m_step();
    bit wr, clr, st, gr, nirq;
    bit [1:0] w1c, setb;
    int a;
    a = int'(csr_addr);
    wr = csr_valid && csr_write;
    w1c = 0; setb = 0;
    nirq = |(m_stat & m_mask);
    m_rv = csr_valid && !csr_write;
    if (m_rv) m_rd = m_read(a);
    clr = wr && a == 0 && csr_wdata[1];
    if (wr && a == 2) w1c = csr_wdata[1:0];
    for (int c = 0; c < 2; c++) begin
      st = valid[c] && stall[c];
      gr = valid[c] && !stall[c];
      if (st && m_limit != 0 && m_run[c] + 1 == m_limit) setb[c] = 1;
      if (clr) begin
        m_gnt[c] = 0; m_stl[c] = 0; m_run[c] = 0;
      end else begin
        if (m_en && gr && m_gnt[c] < 64'hFFFF_FFFF) m_gnt[c]++;
        if (m_en && st && m_stl[c] < 64'hFFFF_FFFF) m_stl[c]++;
        m_run[c] = st ? ((m_run[c] < 65535) ? m_run[c] + 1 : 65535) : 0;
      end
    end
    m_stat = (m_stat & ~w1c) | setb;
    m_irq = nirq;
    if (wr) begin
      if (a == 0) m_en = csr_wdata[0];
      if (a == 1) m_limit = int'(csr_wdata[15:0]);
      if (a == 3) m_mask = csr_wdata[1:0];
      if (a == 'h10 || a == 'h11) m_cred[a-'h10] = int'(csr_wdata[2:0]);
    end
  endtask

  // Advance the model on each edge, compare just after it.
  always @(posedge clk) begin
    if (rst) m_reset();
    else m_step();
    #1;
    if (chk_en) begin
      check("m_rvalid", 32'(csr_rvalid), 32'(m_rv));
      if (m_rv) check("m_rdata", csr_rdata, m_rd);
      check("m_credits", 32'(arb_credits),
            32'({m_cred[1][2:0], m_cred[0][2:0]}));
      check("m_irq", 32'(starve_irq), 32'(m_irq));
    end
  end

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    csr_valid = 1; csr_write = 1; csr_addr = a; csr_wdata = d;
    @(negedge clk);
    csr_valid = 0; csr_write = 0;
  endtask

  task automatic rd_chk(input string nm, input logic [7:0] a,
                        input logic [31:0] exp);
    csr_valid = 1; csr_write = 0; csr_addr = a;
    @(negedge clk);
    csr_valid = 0;
    check({nm, "_rv"}, 32'(csr_rvalid), 32'd1);
    check(nm, csr_rdata, exp);
  endtask

  task automatic traffic(input logic [1:0] v, input logic [1:0] s,
                         input int n);
    valid = v; stall = s;
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 0;
    chk_en = 1;
    @(negedge clk);
    check("rst_credits", 32'(arb_credits), 32'h09);
    check("rst_irq", 32'(starve_irq), 32'd0);
    check("rst_rvalid", 32'(csr_rvalid), 32'd0);
    check("rst_rdata", csr_rdata, 32'd0);
    rd_chk("rst_ctrl", 8'h00, 32'h1);
    rd_chk("rst_limit", 8'h01, 32'd256);
    rd_chk("rst_gnt0", 8'h20, 32'd0);

    wr(8'h11, 32'd5);
    check("cred1_out", 32'(arb_credits[5:3]), 32'd5);
    rd_chk("cred1_rd", 8'h11, 32'd5);
    rd_chk("unmapped", 8'h7F, 32'd0);
    wr(8'h12, 32'd7);
    check("cred_hole", 32'(arb_credits), 32'h29);
    rd_chk("cred_hole_rd", 8'h12, 32'd0);

    traffic(2'b01, 2'b00, 10);
    traffic(2'b01, 2'b01, 4);
    traffic(2'b00, 2'b00, 1);
    rd_chk("gnt0", 8'h20, 32'd10);
    rd_chk("stl0", 8'h30, 32'd4);

    wr(8'h00, 32'h0);
    traffic(2'b01, 2'b00, 5);
    traffic(2'b01, 2'b01, 3);
    traffic(2'b00, 2'b00, 1);
    rd_chk("gnt0_off", 8'h20, 32'd10);
    rd_chk("stl0_off", 8'h30, 32'd4);
    wr(8'h00, 32'h1);

    force dut.g_cli[0].u_cli.grant_q = 32'hFFFF_FFFD;
    m_gnt[0] = 64'hFFFF_FFFD;
    #1;
    release dut.g_cli[0].u_cli.grant_q;
    traffic(2'b01, 2'b00, 4);
    traffic(2'b00, 2'b00, 1);
    rd_chk("gnt0_sat", 8'h20, 32'hFFFF_FFFF);

    valid = 2'b01; stall = 2'b00;
    wr(8'h00, 32'h3);
    valid = 2'b00;
    rd_chk("gnt0_clr", 8'h20, 32'd0);
    rd_chk("ctrl_clr", 8'h00, 32'h1);

    wr(8'h01, 32'd8);
    wr(8'h03, 32'h2);
    traffic(2'b10, 2'b10, 7);
    traffic(2'b10, 2'b00, 1);
    traffic(2'b00, 2'b00, 1);
    rd_chk("stat_7", 8'h02, 32'd0);
    traffic(2'b10, 2'b10, 8);
    check("irq_lag", 32'(starve_irq), 32'd0);
    traffic(2'b10, 2'b10, 1);
    check("irq_set", 32'(starve_irq), 32'd1);
    rd_chk("stat_8", 8'h02, 32'h2);
    wr(8'h02, 32'h2);
    traffic(2'b10, 2'b10, 3);
    check("irq_drop", 32'(starve_irq), 32'd0);
    rd_chk("stat_w1c", 8'h02, 32'd0);
    traffic(2'b00, 2'b00, 1);

    traffic(2'b10, 2'b10, 7);
    wr(8'h02, 32'h2);
    traffic(2'b00, 2'b00, 1);
    rd_chk("stat_race", 8'h02, 32'h2);
    wr(8'h02, 32'h2);

    wr(8'h01, 32'd0);
    traffic(2'b10, 2'b10, 20);
    traffic(2'b00, 2'b00, 1);
    rd_chk("stat_lim0", 8'h02, 32'd0);

    wr(8'h01, 32'd3);
    traffic(2'b11, 2'b01, 2);
    rd_chk("stl0_pre", 8'h30, 32'd2);
    rst = 1;
    #1;
    check("arst_credits", 32'(arb_credits), 32'h09);
    check("arst_irq", 32'(starve_irq), 32'd0);
    check("arst_rvalid", 32'(csr_rvalid), 32'd0);
    @(negedge clk);
    rst = 0;
    valid = 0; stall = 0;
    rd_chk("arst_ctrl", 8'h00, 32'h1);
    rd_chk("arst_gnt1", 8'h21, 32'd0);
    rd_chk("arst_stl0", 8'h30, 32'd0);
    rd_chk("arst_limit", 8'h01, 32'd256);
    rd_chk("arst_stat", 8'h02, 32'd0);

    repeat (2) @(negedge clk);
    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
